// File: rtl/pcie_cntl_rx_fifo_arb_if.sv
// pcie_cntl_rx_fifo_arb_if
// Purpose : bundles the two producer request/beat channels and the RX FIFO
//           write-side signals seen by the RX FIFO write-port arbiter.
// Signals : req0_*/req1_* request, length, grant, beat valid/ready/data;
//           fifo_wr_en/fifo_wr_data/fifo_full_n/fifo_almost_full_n FIFO
//           write side; busy arbiter activity flag.
// Modports: slave  - arbiter view (requests/FIFO status in, grants/writes out)
//           master - producer/FIFO/environment view (mirror of slave)
interface pcie_cntl_rx_fifo_arb_if #(
   parameter int P_FIFO_DATA_WIDTH = 512
);
   logic                         req0_req;
   logic [2:0]                   req0_len;
   logic                         req0_gnt;
   logic                         req0_valid;
   logic [P_FIFO_DATA_WIDTH-1:0] req0_data;
   logic                         req0_ready;

   logic                         req1_req;
   logic [2:0]                   req1_len;
   logic                         req1_gnt;
   logic                         req1_valid;
   logic [P_FIFO_DATA_WIDTH-1:0] req1_data;
   logic                         req1_ready;

   logic                         fifo_wr_en;
   logic [P_FIFO_DATA_WIDTH-1:0] fifo_wr_data;
   logic                         fifo_full_n;
   logic                         fifo_almost_full_n;

   logic                         busy;

   modport slave (
      input  req0_req, req0_len, req0_valid, req0_data,
      input  req1_req, req1_len, req1_valid, req1_data,
      input  fifo_full_n, fifo_almost_full_n,
      output req0_gnt, req0_ready, req1_gnt, req1_ready,
      output fifo_wr_en, fifo_wr_data, busy
   );

   modport master (
      output req0_req, req0_len, req0_valid, req0_data,
      output req1_req, req1_len, req1_valid, req1_data,
      output fifo_full_n, fifo_almost_full_n,
      input  req0_gnt, req0_ready, req1_gnt, req1_ready,
      input  fifo_wr_en, fifo_wr_data, busy
   );
endinterface

// File: rtl/pcie_cntl_rx_fifo_arb.sv
// pcie_cntl_rx_fifo_arb
// Purpose : burst-granular round-robin arbiter sharing the RX FIFO write
//           port between two producers. A whole burst (1-8 beats) is granted
//           only while the registered almost-full flag guarantees room for a
//           maximum burst; the granted producer's beats are then muxed into
//           the FIFO, followed by one idle GAP cycle.
// Ports   : clk   - sole clock
//           rst_n - synchronous reset, active low
//           bus   - slave modport of pcie_cntl_rx_fifo_arb_if (request,
//                   grant, beat handshakes, FIFO write side, busy)
module pcie_cntl_rx_fifo_arb #(
   parameter int P_FIFO_DATA_WIDTH = 512
) (
   input  logic                         clk,
   input  logic                         rst_n,
   pcie_cntl_rx_fifo_arb_if.slave       bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic       last_q, last_d;
   logic [2:0] len_q, len_d;
   logic [2:0] beat_cnt_q, beat_cnt_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;

   logic                         win;
   logic                         beat_acc;
   logic                         rdy0;
   logic                         rdy1;
   logic [P_FIFO_DATA_WIDTH-1:0] wr_data;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= 1'b0;
         last_q     <= 1'b1;
         len_q      <= '0;
         beat_cnt_q <= '0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      win        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((bus.req0_req | bus.req1_req) & bus.fifo_almost_full_n) begin
               // On a tie the requester not served last wins.
               win        = (bus.req0_req & bus.req1_req) ? ~last_q : bus.req1_req;
               sel_d      = win;
               last_d     = win;
               len_d      = win ? bus.req1_len : bus.req0_len;
               beat_cnt_d = '0;
               gnt0_d     = ~win;
               gnt1_d     = win;
               state_d    = ST_BURST;
            end
         end
         ST_BURST: begin
            if (beat_acc) begin
               // Counter stops at the final beat, so it never wraps.
               if (beat_cnt_q == len_q) state_d = ST_GAP;
               else                     beat_cnt_d = beat_cnt_q + 3'd1;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      // Ready is withheld whenever the FIFO reports full, even mid-burst.
      rdy0     = (state_q == ST_BURST) & ~sel_q & bus.fifo_full_n;
      rdy1     = (state_q == ST_BURST) &  sel_q & bus.fifo_full_n;
      beat_acc = sel_q ? (rdy1 & bus.req1_valid) : (rdy0 & bus.req0_valid);
      wr_data  = sel_q ? bus.req1_data : bus.req0_data;

      bus.req0_gnt     = gnt0_q;
      bus.req1_gnt     = gnt1_q;
      bus.req0_ready   = rdy0;
      bus.req1_ready   = rdy1;
      bus.fifo_wr_en   = beat_acc;
      bus.fifo_wr_data = wr_data;
      bus.busy         = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_pcie_cntl_rx_fifo_arb.sv
module tb_pcie_cntl_rx_fifo_arb;

   localparam int W = 512;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pcie_cntl_rx_fifo_arb_if #(.P_FIFO_DATA_WIDTH(W)) bus_if ();

   pcie_cntl_rx_fifo_arb #(.P_FIFO_DATA_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {gnt0, gnt1, ready0, ready1, wr_en, busy}
   function automatic logic [5:0] outs();
      return {bus_if.req0_gnt, bus_if.req1_gnt, bus_if.req0_ready,
              bus_if.req1_ready, bus_if.fifo_wr_en, bus_if.busy};
   endfunction

   function automatic logic [W-1:0] rnd_beat();
      logic [W-1:0] v;
      for (int unsigned i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic idle_inputs();
      bus_if.req0_req           = 1'b0;
      bus_if.req0_len           = 3'd0;
      bus_if.req0_valid         = 1'b0;
      bus_if.req0_data          = '0;
      bus_if.req1_req           = 1'b0;
      bus_if.req1_len           = 3'd0;
      bus_if.req1_valid         = 1'b0;
      bus_if.req1_data          = '0;
      bus_if.fifo_full_n        = 1'b1;
      bus_if.fifo_almost_full_n = 1'b1;
   endtask

   // Leaves time at posedge+1 with the design in IDLE and reset released.
   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus_if.req0_req   = 1'b1;
      bus_if.req1_req   = 1'b1;
      bus_if.req0_valid = 1'b1;
      bus_if.req1_valid = 1'b1;
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      if (outs() !== 6'b000000) begin
         $display("FAIL reset_outputs: got %b expected %b", outs(), 6'b000000);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      #1;
      if (outs() !== 6'b000000) begin
         $display("FAIL reset_held: got %b expected %b", outs(), 6'b000000);
         n_fail++;
      end
      n_checks++;
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_single_burst();
      logic [W-1:0] beats [8];
      logic [5:0]   exp;
      for (int i = 0; i < 8; i++) beats[i] = rnd_beat();
      apply_reset();
      bus_if.req0_req = 1'b1;
      bus_if.req0_len = 3'd7;
      #1;
      if (outs() !== 6'b000000) begin
         $display("FAIL single_idle: got %b expected %b", outs(), 6'b000000);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      for (int i = 0; i < 8; i++) begin
         bus_if.req0_req   = 1'b0;
         bus_if.req0_valid = 1'b1;
         bus_if.req0_data  = beats[i];
         #1;
         exp = {(i == 0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
         if (outs() !== exp) begin
            $display("FAIL single_beat%0d: got %b expected %b", i, outs(), exp);
            n_fail++;
         end
         n_checks++;
         if (bus_if.fifo_wr_data !== beats[i]) begin
            $display("FAIL single_data%0d: got %h expected %h", i, bus_if.fifo_wr_data, beats[i]);
            n_fail++;
         end
         n_checks++;
         next_cycle();
      end
      bus_if.req0_data = rnd_beat();
      #1;
      if (outs() !== 6'b000001) begin
         $display("FAIL single_gap: got %b expected %b", outs(), 6'b000001);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      bus_if.req0_valid = 1'b0;
      #1;
      if (outs() !== 6'b000000) begin
         $display("FAIL single_back_idle: got %b expected %b", outs(), 6'b000000);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_round_robin();
      logic [5:0]   exp;
      logic [W-1:0] d0, d1;
      int           writes;
      int           k;
      writes = 0;
      apply_reset();
      bus_if.req0_req   = 1'b1;
      bus_if.req1_req   = 1'b1;
      bus_if.req0_valid = 1'b1;
      bus_if.req1_valid = 1'b1;
      for (int c = 0; c < 13; c++) begin
         d0 = rnd_beat();
         d1 = rnd_beat();
         bus_if.req0_data = d0;
         bus_if.req1_data = d1;
         #1;
         // Grants every 3 cycles starting at cycle 1, alternating req0/req1.
         exp = 6'b000000;
         if (c >= 1 && (c - 1) % 3 == 0) begin
            k = (c - 1) / 3;
            exp = (k % 2 == 0) ? 6'b101011 : 6'b010111;
         end else if (c >= 1 && (c - 1) % 3 == 1) begin
            exp = 6'b000001;
         end
         if (outs() !== exp) begin
            $display("FAIL rr_cycle%0d: got %b expected %b", c, outs(), exp);
            n_fail++;
         end
         n_checks++;
         if (exp[1]) begin
            writes++;
            k = (c - 1) / 3;
            if (bus_if.fifo_wr_data !== ((k % 2 == 0) ? d0 : d1)) begin
               $display("FAIL rr_data%0d: got %h expected %h", c, bus_if.fifo_wr_data,
                        (k % 2 == 0) ? d0 : d1);
               n_fail++;
            end
            n_checks++;
         end
         next_cycle();
      end
      if (writes != 4) begin
         $display("FAIL rr_write_count: got %0d expected %0d", writes, 4);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      apply_reset();
      bus_if.fifo_almost_full_n = 1'b0;
      bus_if.req0_req = 1'b1;
      bus_if.req1_req = 1'b1;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (outs() !== 6'b000000) bad++;
         next_cycle();
      end
      if (bad != 0) begin
         $display("FAIL bp_no_grant: got %0d active cycles expected %0d", bad, 0);
         n_fail++;
      end
      n_checks++;
      bus_if.fifo_almost_full_n = 1'b1;
      #1;
      if (outs() !== 6'b000000) begin
         $display("FAIL bp_release_cycle: got %b expected %b", outs(), 6'b000000);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      bus_if.req0_req   = 1'b0;
      bus_if.req1_req   = 1'b0;
      bus_if.req0_valid = 1'b1;
      #1;
      if (outs() !== 6'b101011) begin
         $display("FAIL bp_grant: got %b expected %b", outs(), 6'b101011);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      bus_if.req0_valid = 1'b0;
      next_cycle();
   endtask

   task automatic test_stalls();
      bit           pat [7];
      logic [W-1:0] beats [4];
      logic [5:0]   exp;
      int           k;
      int           writes;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) beats[i] = rnd_beat();
      k = 0;
      writes = 0;
      apply_reset();
      bus_if.req1_req = 1'b1;
      bus_if.req1_len = 3'd3;
      next_cycle();
      for (int i = 0; i < 7; i++) begin
         bus_if.req1_req   = 1'b0;
         bus_if.req1_valid = pat[i];
         bus_if.req1_data  = beats[k];
         #1;
         exp = {1'b0, (i == 0), 1'b0, 1'b1, pat[i], 1'b1};
         if (outs() !== exp) begin
            $display("FAIL stall_cycle%0d: got %b expected %b", i, outs(), exp);
            n_fail++;
         end
         n_checks++;
         if (bus_if.fifo_wr_en === 1'b1) begin
            writes++;
            if (bus_if.fifo_wr_data !== beats[k]) begin
               $display("FAIL stall_data%0d: got %h expected %h", k, bus_if.fifo_wr_data, beats[k]);
               n_fail++;
            end
            n_checks++;
         end
         if (pat[i]) k++;
         next_cycle();
      end
      bus_if.req1_valid = 1'b1;
      bus_if.req1_data  = rnd_beat();
      #1;
      if (outs() !== 6'b000001) begin
         $display("FAIL stall_gap: got %b expected %b", outs(), 6'b000001);
         n_fail++;
      end
      n_checks++;
      if (writes != 4) begin
         $display("FAIL stall_write_count: got %0d expected %0d", writes, 4);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      bus_if.req1_valid = 1'b0;
      next_cycle();
   endtask

   task automatic test_full_safety();
      logic [W-1:0] beats [6];
      logic [5:0]   exp;
      logic         fn;
      int           k;
      int           writes;
      for (int i = 0; i < 6; i++) beats[i] = rnd_beat();
      k = 0;
      writes = 0;
      apply_reset();
      bus_if.req0_req = 1'b1;
      bus_if.req0_len = 3'd5;
      next_cycle();
      for (int i = 1; i <= 9; i++) begin
         fn = !(i >= 3 && i <= 5);
         bus_if.req0_req    = 1'b0;
         bus_if.req0_valid  = 1'b1;
         bus_if.req0_data   = beats[k];
         bus_if.fifo_full_n = fn;
         #1;
         exp = {(i == 1), 1'b0, fn, 1'b0, fn, 1'b1};
         if (outs() !== exp) begin
            $display("FAIL full_cycle%0d: got %b expected %b", i, outs(), exp);
            n_fail++;
         end
         n_checks++;
         if (bus_if.fifo_wr_en === 1'b1) begin
            writes++;
            if (bus_if.fifo_wr_data !== beats[k]) begin
               $display("FAIL full_data%0d: got %h expected %h", k, bus_if.fifo_wr_data, beats[k]);
               n_fail++;
            end
            n_checks++;
         end
         if (fn) k++;
         next_cycle();
      end
      bus_if.fifo_full_n = 1'b1;
      bus_if.req0_data   = rnd_beat();
      #1;
      if (outs() !== 6'b000001) begin
         $display("FAIL full_gap: got %b expected %b", outs(), 6'b000001);
         n_fail++;
      end
      n_checks++;
      if (writes != 6) begin
         $display("FAIL full_write_count: got %0d expected %0d", writes, 6);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      bus_if.req0_valid = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid_burst();
      logic [W-1:0] d0;
      apply_reset();
      bus_if.req0_req = 1'b1;
      bus_if.req0_len = 3'd7;
      next_cycle();
      bus_if.req0_req   = 1'b0;
      bus_if.req0_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus_if.req0_data = rnd_beat();
         next_cycle();
      end
      rst_n = 1'b0;
      bus_if.req0_data = rnd_beat();
      next_cycle();
      rst_n = 1'b1;
      bus_if.req0_req   = 1'b1;
      bus_if.req1_req   = 1'b1;
      bus_if.req0_len   = 3'd0;
      bus_if.req1_len   = 3'd0;
      bus_if.req1_valid = 1'b1;
      #1;
      if (outs() !== 6'b000000) begin
         $display("FAIL midrst_outputs: got %b expected %b", outs(), 6'b000000);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      d0 = rnd_beat();
      bus_if.req0_data = d0;
      bus_if.req1_data = rnd_beat();
      bus_if.req0_req  = 1'b0;
      bus_if.req1_req  = 1'b0;
      #1;
      if (outs() !== 6'b101011) begin
         $display("FAIL midrst_tie_req0: got %b expected %b", outs(), 6'b101011);
         n_fail++;
      end
      n_checks++;
      if (bus_if.fifo_wr_data !== d0) begin
         $display("FAIL midrst_data: got %h expected %h", bus_if.fifo_wr_data, d0);
         n_fail++;
      end
      n_checks++;
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   // Random traffic against a transaction-level model: each requester owns a
   // list of beats; the model tracks who owns the port and how many beats
   // remain, and decides winners from the round-robin rule.
   task automatic test_random();
      bit           r_req    [2];
      logic [2:0]   r_len    [2];
      logic [W-1:0] r_beats  [2][8];
      int           r_idx    [2];
      bit           r_active [2];
      bit           gp       [2];
      int           owner, left, glen, w;
      bit           gap, nxt_gap, last;
      logic         fn, afn, v0, v1;
      logic [5:0]   exp;
      bit           e_wr, e_busy;
      for (int x = 0; x < 2; x++) begin
         r_req[x] = 0; r_active[x] = 0; r_idx[x] = 0; gp[x] = 0; r_len[x] = 3'd0;
      end
      owner = -1; left = 0; glen = 0; gap = 0; last = 1;
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int x = 0; x < 2; x++) begin
            if (gp[x]) begin
               r_req[x] = 0;
               r_active[x] = 1;
            end else if (!r_req[x] && !r_active[x] && $urandom_range(0, 3) == 0) begin
               r_req[x] = 1;
               r_len[x] = 3'($urandom_range(0, 7));
               r_idx[x] = 0;
               for (int b = 0; b < 8; b++) r_beats[x][b] = rnd_beat();
            end
         end
         v0  = r_active[0] ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         v1  = r_active[1] ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         fn  = ($urandom_range(0, 9) != 0);
         afn = ($urandom_range(0, 4) != 0);
         bus_if.req0_req   = r_req[0];
         bus_if.req0_len   = r_len[0];
         bus_if.req0_valid = v0;
         bus_if.req0_data  = r_active[0] ? r_beats[0][r_idx[0]] : rnd_beat();
         bus_if.req1_req   = r_req[1];
         bus_if.req1_len   = r_len[1];
         bus_if.req1_valid = v1;
         bus_if.req1_data  = r_active[1] ? r_beats[1][r_idx[1]] : rnd_beat();
         bus_if.fifo_full_n        = fn;
         bus_if.fifo_almost_full_n = afn;
         #1;
         if (gp[0] || gp[1]) begin
            owner = gp[1] ? 1 : 0;
            left  = glen + 1;
         end
         e_wr   = (owner == 0) ? (fn & v0) : (owner == 1) ? (fn & v1) : 1'b0;
         e_busy = (owner >= 0) || gap;
         exp = {gp[0], gp[1], (owner == 0) & fn, (owner == 1) & fn, e_wr, e_busy};
         if (outs() !== exp) begin
            $display("FAIL rand_cycle%0d: got %b expected %b", c, outs(), exp);
            n_fail++;
         end
         n_checks++;
         if (e_wr) begin
            if (bus_if.fifo_wr_data !== r_beats[owner][r_idx[owner]]) begin
               $display("FAIL rand_data%0d: got %h expected %h", c, bus_if.fifo_wr_data,
                        r_beats[owner][r_idx[owner]]);
               n_fail++;
            end
            n_checks++;
         end
         gp[0] = 0;
         gp[1] = 0;
         nxt_gap = 0;
         if (e_wr) begin
            r_idx[owner]++;
            left--;
            if (left == 0) begin
               r_active[owner] = 0;
               owner   = -1;
               nxt_gap = 1;
            end
         end
         gap = nxt_gap;
         if (!e_busy && afn && (r_req[0] || r_req[1])) begin
            w = (r_req[0] && r_req[1]) ? int'(!last) : (r_req[1] ? 1 : 0);
            gp[w] = 1;
            glen  = int'(r_len[w]);
            last  = (w == 1);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      test_reset();
      test_single_burst();
      test_round_robin();
      test_backpressure();
      test_stalls();
      test_full_safety();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
